// File: rtl/aes_decryption_core.sv
// AES-128 inverse cipher, iterative (one round per clock) with on-chip key expansion.
// Latency: key schedule 10 cycles after LoadKey; plaintext 10 cycles after LoadData.
// Backpressure: none; strobes that arrive while the core cannot take them are dropped.
module aes_decryption_core (
   input  logic         clk,
   input  logic         rst,
   input  logic         LoadKey,
   input  logic         LoadData,
   input  logic [127:0] KeyCipherText_in,
   output logic [127:0] PlainText_out,
   output logic         PTValid,
   output logic         KeyReady,
   output logic         Busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      KEYEXP  = 2'd1,
      READY   = 2'd2,
      DECRYPT = 2'd3
   } state_t;

   // ---------------------------------------------------------------
   // GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1 (0x11b)
   // ---------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = x;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   // S-boxes are computed from the field inverse and the affine map rather
   // than stored, so there is no table to transcribe.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return ginv(y);
   endfunction

   // ---------------------------------------------------------------
   // Key schedule helpers
   // ---------------------------------------------------------------
   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [31:0] w3;
      logic [31:0] t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // ---------------------------------------------------------------
   // Inverse round transforms; byte n of the block is bits [127-8n -: 8],
   // column-major, so byte (row r, column c) is n = 4c + r.
   // ---------------------------------------------------------------
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int n = 0; n < 16; n++) begin
         o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   state_t         state;
   state_t         state_nxt;
   logic [127:0]   rk [0:10];
   logic [3:0]     key_cnt;     // index of the round key produced at the next edge
   logic [3:0]     round_cnt;   // round applied at the next edge (9..0)
   logic [127:0]   dstate;      // working block, never visible on the output

   logic           key_start;
   logic           key_step;
   logic           data_start;
   logic           round_step;
   logic           done;

   logic [127:0]   rk_prev;
   logic [127:0]   key_next;
   logic [127:0]   rk_round;
   logic [127:0]   round_pre;
   logic [127:0]   round_out;

   assign rk_prev   = rk[key_cnt - 4'd1];
   assign key_next  = expand_key(rk_prev, rcon(key_cnt));
   assign rk_round  = rk[round_cnt];
   assign round_pre = inv_sub_bytes(inv_shift_rows(dstate)) ^ rk_round;
   assign round_out = (round_cnt == 4'd0) ? round_pre : inv_mix_columns(round_pre);

   assign Busy = (state == KEYEXP) || (state == DECRYPT);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state and datapath controls; LoadKey outranks LoadData and is locked out mid-block
   always_comb begin
      state_nxt  = state;
      key_start  = 1'b0;
      key_step   = 1'b0;
      data_start = 1'b0;
      round_step = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (LoadKey) begin
               key_start = 1'b1;
               state_nxt = KEYEXP;
            end
         end
         KEYEXP: begin
            if (LoadKey) begin
               key_start = 1'b1;
            end else begin
               key_step = 1'b1;
               if (key_cnt == 4'd10) state_nxt = READY;
            end
         end
         READY: begin
            if (LoadKey) begin
               key_start = 1'b1;
               state_nxt = KEYEXP;
            end else if (LoadData) begin
               data_start = 1'b1;
               state_nxt  = DECRYPT;
            end
         end
         DECRYPT: begin
            round_step = 1'b1;
            if (round_cnt == 4'd0) begin
               done      = 1'b1;
               state_nxt = READY;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Round-key store, round engine and output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 11; i++) rk[i] <= '0;
         key_cnt       <= '0;
         round_cnt     <= '0;
         dstate        <= '0;
         PlainText_out <= '0;
         PTValid       <= 1'b0;
         KeyReady      <= 1'b0;
      end else begin
         PTValid <= 1'b0;
         if (key_start) begin
            rk[0]    <= KeyCipherText_in;
            key_cnt  <= 4'd1;
            KeyReady <= 1'b0;
         end else if (key_step) begin
            rk[key_cnt] <= key_next;
            if (key_cnt == 4'd10) begin
               key_cnt  <= 4'd0;
               KeyReady <= 1'b1;
            end else begin
               key_cnt <= key_cnt + 4'd1;
            end
         end
         if (data_start) begin
            dstate    <= KeyCipherText_in ^ rk[10];
            round_cnt <= 4'd9;
         end else if (round_step) begin
            if (done) begin
               PlainText_out <= round_out;
               PTValid       <= 1'b1;
            end else begin
               dstate    <= round_out;
               round_cnt <= round_cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_decryption_core.sv
// Scoreboard bench for the AES-128 decryption core.
// Expected plaintexts come from published AES-128 vectors.
// Drives on the falling edge; a monitor checks every falling edge.
module tb_aes_decryption_core;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         LoadKey = 1'b0;
   logic         LoadData = 1'b0;
   logic [127:0] KeyCipherText_in = '0;
   logic [127:0] PlainText_out;
   logic         PTValid;
   logic         KeyReady;
   logic         Busy;

   aes_decryption_core dut (
      .clk              (clk),
      .rst              (rst),
      .LoadKey          (LoadKey),
      .LoadData         (LoadData),
      .KeyCipherText_in (KeyCipherText_in),
      .PlainText_out    (PlainText_out),
      .PTValid          (PTValid),
      .KeyReady         (KeyReady),
      .Busy             (Busy)
   );

   localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   // Ciphertext/plaintext pairs under K2, decrypted back to back
   logic [127:0] ct_tab [0:4];
   logic [127:0] pt_tab [0:4];

   int           n_chk  = 0;
   int           n_fail = 0;
   int           cyc    = 0;
   logic [127:0] exp_q [$];
   int           lat_q [$];
   logic [127:0] last_pt  = '0;
   logic         prev_vld = 1'b0;
   logic [127:0] exp_pt;
   int           st_cyc;
   int           k0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every PTValid must match the oldest accepted block, and the
   // output must otherwise hold the last completed plaintext.
   always @(negedge clk) begin
      if (!rst) last_pt = '0;
      if (PTValid) begin
         chk("ptvalid_width", 128'(prev_vld), 128'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_ptvalid", 128'd1, 128'd0);
         end else begin
            exp_pt = exp_q.pop_front();
            st_cyc = lat_q.pop_front();
            chk("plaintext", PlainText_out, exp_pt);
            chk("latency", 128'(cyc - st_cyc), 128'd10);
            last_pt = exp_pt;
         end
      end else begin
         chk("pt_hold", PlainText_out, last_pt);
      end
      prev_vld = PTValid;
   end

   task automatic load_key(input logic [127:0] k, output int kstart);
      KeyCipherText_in = k;
      LoadKey = 1'b1;
      kstart = cyc + 1;
      @(negedge clk);
      LoadKey = 1'b0;
      chk("keyready_cleared", 128'(KeyReady), 128'd0);
      chk("busy_keyexp", 128'(Busy), 128'd1);
   endtask

   task automatic wait_key(input int kstart);
      int n;
      n = 0;
      while (!KeyReady && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("keyready_latency", 128'(cyc - kstart), 128'd10);
      chk("busy_ready", 128'(Busy), 128'd0);
   endtask

   task automatic send_data(input logic [127:0] ct, input logic [127:0] pt, input bit accept);
      KeyCipherText_in = ct;
      LoadData = 1'b1;
      if (accept) begin
         exp_q.push_back(pt);
         lat_q.push_back(cyc + 1);
      end
      @(negedge clk);
      LoadData = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(exp_q.size()), 128'd0);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ct_tab[0] = C2;                                       pt_tab[0] = P2;
      ct_tab[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;    pt_tab[1] = 128'h6bc1bee22e409f96e93d7e117393172a;
      ct_tab[2] = 128'hf5d3d58503b9699de785895a96fdbaaf;    pt_tab[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      ct_tab[3] = 128'h43b1cd7f598ece23881b00e3ed030688;    pt_tab[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      ct_tab[4] = 128'h7b0c785e27e8ad3f8223207104725dd4;    pt_tab[4] = 128'hf69f2445df4f9b17ad2b417be66c3710;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pt", PlainText_out, 128'd0);
      chk("rst_ptvalid", 128'(PTValid), 128'd0);
      chk("rst_keyready", 128'(KeyReady), 128'd0);
      chk("rst_busy", 128'(Busy), 128'd0);
      chk("rst_rk10", dut.rk[10], 128'd0);

      // LoadKey in the very first cycle after release, then the FIPS-197 C.1 block
      rst = 1'b1;
      load_key(K1, k0);
      wait_key(k0);
      send_data(C1, P1, 1'b1);
      repeat (3) @(negedge clk);
      send_data(C2, P2, 1'b0);                  // mid-block LoadData is dropped
      KeyCipherText_in = K2;
      LoadKey = 1'b1;                           // mid-block LoadKey is dropped
      @(negedge clk);
      LoadKey = 1'b0;
      chk("keyready_kept", 128'(KeyReady), 128'd1);
      drain();
      send_data(C1, P1, 1'b1);                  // schedule must still be K1's
      drain();

      // Second key, stored rk10, then a stream at the full 11-cycle rate
      load_key(K2, k0);
      wait_key(k0);
      chk("rk10", dut.rk[10], RK10);
      for (int i = 0; i < 5; i++) begin
         send_data(ct_tab[i], pt_tab[i], 1'b1);
         if (i < 4) repeat (10) @(negedge clk);
      end
      drain();

      // LoadData during KEYEXP ignored; LoadKey at KEYEXP cycle 5 restarts
      load_key(K1, k0);
      send_data(C1, P1, 1'b0);
      repeat (3) @(negedge clk);
      load_key(K2, k0);
      wait_key(k0);
      send_data(C2, P2, 1'b1);
      drain();

      // LoadKey and LoadData together in READY: key wins, data dropped
      KeyCipherText_in = K1;
      LoadKey  = 1'b1;
      LoadData = 1'b1;
      k0 = cyc + 1;
      @(negedge clk);
      LoadKey  = 1'b0;
      LoadData = 1'b0;
      chk("sim_keyready_cleared", 128'(KeyReady), 128'd0);
      wait_key(k0);
      send_data(C1, P1, 1'b1);
      drain();

      // Reset while round 4 is pending
      send_data(C2, P2, 1'b0);                  // wrong key: result not checked, block is aborted
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_pt", PlainText_out, 128'd0);
      chk("abort_ptvalid", 128'(PTValid), 128'd0);
      chk("abort_keyready", 128'(KeyReady), 128'd0);
      chk("abort_busy", 128'(Busy), 128'd0);
      chk("abort_rk10", dut.rk[10], 128'd0);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_data(C1, P1, 1'b0);                  // no key after reset: ignored
      repeat (15) @(negedge clk);
      chk("post_rst_keyready", 128'(KeyReady), 128'd0);
      chk("post_rst_busy", 128'(Busy), 128'd0);
      load_key(K2, k0);
      wait_key(k0);
      send_data(C2, P2, 1'b1);
      drain();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
